// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/sequencing controller:
// FSM state encodings, forwarding select codes, register index width,
// and the producer-match / forwarding-priority helpers.
package pipeline_ctrl_pkg;

    // Register index width (x0..x31)
    localparam int unsigned REG_NUM = 5;

    // Controller FSM states; encoding 2'd3 is unused and treated as CTRL_RUN
    typedef enum logic [1:0] {
        CTRL_RUN        = 2'd0,
        CTRL_LOAD_STALL = 2'd1,
        CTRL_MEM_WAIT   = 2'd2
    } ctrl_state_e;

    // Operand source selects for the ID operand muxes
    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_EX  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    // A stage produces a value needed by an ID source; x0 never matches
    function automatic logic producer_match(input logic               valid,
                                            input logic               reg_we,
                                            input logic [REG_NUM-1:0] rd,
                                            input logic [REG_NUM-1:0] rs,
                                            input logic               use_rs);
        return valid & reg_we & use_rs & (rd == rs) & (rs != '0);
    endfunction

    // The youngest producer (EX) wins over MEM
    function automatic logic [1:0] fwd_select(input logic ex_match, input logic mem_match);
        if (ex_match) begin
            return FWD_EX;
        end else if (mem_match) begin
            return FWD_MEM;
        end
        return FWD_REG;
    endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Pipeline <-> hazard controller bundle: per-stage instruction qualifiers,
// the MEM-stage data memory handshake, and the control/forwarding outputs.
// master = pipeline datapath side, slave = controller side.
interface pipeline_ctrl_if;
    import pipeline_ctrl_pkg::*;

    logic               id_valid;
    logic [REG_NUM-1:0] id_rs1;
    logic [REG_NUM-1:0] id_rs2;
    logic               id_use_rs1;
    logic               id_use_rs2;
    logic               ex_valid;
    logic               ex_reg_we;
    logic               ex_is_load;
    logic [REG_NUM-1:0] ex_rd;
    logic               mem_valid;
    logic               mem_reg_we;
    logic [REG_NUM-1:0] mem_rd;
    logic               br_taken;
    logic               dmem_req;
    logic               dmem_ack;

    logic               stall_if;
    logic               stall_id;
    logic               bubble_ex;
    logic               flush_id;
    logic               stall_mem;
    logic [1:0]         fwd_src1;
    logic [1:0]         fwd_src2;

    modport master (
        output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
        output ex_valid, ex_reg_we, ex_is_load, ex_rd,
        output mem_valid, mem_reg_we, mem_rd,
        output br_taken, dmem_req, dmem_ack,
        input  stall_if, stall_id, bubble_ex, flush_id, stall_mem, fwd_src1, fwd_src2
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
        input  ex_valid, ex_reg_we, ex_is_load, ex_rd,
        input  mem_valid, mem_reg_we, mem_rd,
        input  br_taken, dmem_req, dmem_ack,
        output stall_if, stall_id, bubble_ex, flush_id, stall_mem, fwd_src1, fwd_src2
    );

endinterface

// File: rtl/pipeline_hazard_unit.sv
// Combinational hazard detection: per-source EX/MEM producer matches, the
// load-use flag, the operand forwarding selects and the resulting stall request.
// Config macro: PIPELINE_FORWARDING_EN (undefined: no forwarding, every
// EX/MEM match requests a stall).
module pipeline_hazard_unit
    import pipeline_ctrl_pkg::*;
(
    input  logic               id_use_rs1,
    input  logic               id_use_rs2,
    input  logic [REG_NUM-1:0] id_rs1,
    input  logic [REG_NUM-1:0] id_rs2,
    input  logic               ex_valid,
    input  logic               ex_reg_we,
    input  logic               ex_is_load,
    input  logic [REG_NUM-1:0] ex_rd,
    input  logic               mem_valid,
    input  logic               mem_reg_we,
    input  logic [REG_NUM-1:0] mem_rd,
    output logic               stall_req,
    output logic [1:0]         fwd_src1,
    output logic [1:0]         fwd_src2
);

    logic ex_match1;
    logic ex_match2;
    logic mem_match1;
    logic mem_match2;
    logic load_use;

    assign ex_match1  = producer_match(ex_valid, ex_reg_we, ex_rd, id_rs1, id_use_rs1);
    assign ex_match2  = producer_match(ex_valid, ex_reg_we, ex_rd, id_rs2, id_use_rs2);
    assign mem_match1 = producer_match(mem_valid, mem_reg_we, mem_rd, id_rs1, id_use_rs1);
    assign mem_match2 = producer_match(mem_valid, mem_reg_we, mem_rd, id_rs2, id_use_rs2);

    // A load result is not available until MEM, so EX cannot forward it
    assign load_use = ex_is_load & (ex_match1 | ex_match2);

`ifdef PIPELINE_FORWARDING_EN
    assign fwd_src1  = fwd_select(ex_match1, mem_match1);
    assign fwd_src2  = fwd_select(ex_match2, mem_match2);
    assign stall_req = load_use;
`else
    assign fwd_src1  = FWD_REG;
    assign fwd_src2  = FWD_REG;
    // load_use is a subset of the EX match; any in-flight producer must drain to WB
    assign stall_req = ex_match1 | ex_match2 | mem_match1 | mem_match2 | load_use;
`endif

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard and sequencing controller for the five-stage pipeline. Drives the
// stall, bubble, flush and forwarding controls (all Mealy), freezes the
// pipeline while data memory is outstanding, and counts stalled cycles.
// Config macro: PIPELINE_FORWARDING_EN (see pipeline_hazard_unit).
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    pipeline_ctrl_if.slave   pif,
    output logic [1:0]       ctrl_state,
    output logic [CNT_W-1:0] stall_cnt
);

    ctrl_state_e      state_q;
    ctrl_state_e      state_d;
    logic             stall_req;
    logic             mem_block;
    logic [1:0]       fwd1;
    logic [1:0]       fwd2;
    logic [CNT_W-1:0] cnt_q;

    pipeline_hazard_unit u_hazard (
        .id_use_rs1 (pif.id_use_rs1),
        .id_use_rs2 (pif.id_use_rs2),
        .id_rs1     (pif.id_rs1),
        .id_rs2     (pif.id_rs2),
        .ex_valid   (pif.ex_valid),
        .ex_reg_we  (pif.ex_reg_we),
        .ex_is_load (pif.ex_is_load),
        .ex_rd      (pif.ex_rd),
        .mem_valid  (pif.mem_valid),
        .mem_reg_we (pif.mem_reg_we),
        .mem_rd     (pif.mem_rd),
        .stall_req  (stall_req),
        .fwd_src1   (fwd1),
        .fwd_src2   (fwd2)
    );

    assign pif.fwd_src1 = fwd1;
    assign pif.fwd_src2 = fwd2;

    // Memory request not acknowledged in the cycle it is issued
    assign mem_block = pif.dmem_req & ~pif.dmem_ack;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= CTRL_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = CTRL_RUN;
        unique case (state_q)
            CTRL_MEM_WAIT: begin
                state_d = pif.dmem_ack ? CTRL_RUN : CTRL_MEM_WAIT;
            end
            CTRL_LOAD_STALL: begin
                state_d = mem_block ? CTRL_MEM_WAIT : CTRL_RUN;
            end
            default: begin
                if (mem_block) begin
                    state_d = CTRL_MEM_WAIT;
                end else if (pif.br_taken) begin
                    state_d = CTRL_RUN;
                end else if (stall_req & pif.id_valid) begin
`ifdef PIPELINE_FORWARDING_EN
                    state_d = CTRL_LOAD_STALL;
`else
                    // Without forwarding we simply hold in RUN until the match clears
                    state_d = CTRL_RUN;
`endif
                end
            end
        endcase
    end

    // Mealy control outputs
    always_comb begin
        pif.stall_if  = 1'b0;
        pif.stall_id  = 1'b0;
        pif.stall_mem = 1'b0;
        pif.bubble_ex = 1'b0;
        pif.flush_id  = 1'b0;
        unique case (state_q)
            CTRL_MEM_WAIT: begin
                // The ack cycle itself releases the freeze
                if (!pif.dmem_ack) begin
                    pif.stall_mem = 1'b1;
                    pif.stall_if  = 1'b1;
                    pif.stall_id  = 1'b1;
                end
            end
            CTRL_LOAD_STALL: begin
                if (mem_block) begin
                    pif.stall_mem = 1'b1;
                    pif.stall_if  = 1'b1;
                    pif.stall_id  = 1'b1;
                end
            end
            default: begin
                if (mem_block) begin
                    pif.stall_mem = 1'b1;
                    pif.stall_if  = 1'b1;
                    pif.stall_id  = 1'b1;
                end else if (pif.br_taken) begin
                    // Wrong-path instruction in ID is killed; any hazard it had is moot
                    pif.flush_id  = 1'b1;
                    pif.bubble_ex = 1'b1;
                end else if (stall_req & pif.id_valid) begin
                    pif.stall_if  = 1'b1;
                    pif.stall_id  = 1'b1;
                    pif.bubble_ex = 1'b1;
                end
            end
        endcase
    end

    // Saturating stalled-cycle counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (pif.stall_if && (cnt_q != '1)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign ctrl_state = state_q;
    assign stall_cnt  = cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed scenarios followed by random
// stimulus, predicted by a behavioural model and checked by a scoreboard monitor.
module tb_pipeline_ctrl;

    localparam int unsigned CNT_W   = 6;
    localparam int          CNT_MAX = 63;

    typedef struct {
        bit id_valid;
        int rs1;
        int rs2;
        bit use1;
        bit use2;
        bit exv;
        bit exwe;
        bit exld;
        int exrd;
        bit memv;
        bit memwe;
        int memrd;
        bit br;
        bit req;
        bit ack;
    } stim_t;

    typedef struct {
        bit    sif;
        bit    sid;
        bit    bub;
        bit    fl;
        bit    smem;
        int    f1;
        int    f2;
        int    st;
        int    cnt;
        string tag;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic [1:0]       ctrl_state;
    logic [CNT_W-1:0] stall_cnt;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Model: what the pipeline is currently doing (0 running, 1 load bubble, 2 memory wait)
    int   m_mode = 0;
    int   m_cnt  = 0;

    always #5 clk = ~clk;

    pipeline_ctrl_if pif ();

    pipeline_ctrl #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .pif        (pif),
        .ctrl_state (ctrl_state),
        .stall_cnt  (stall_cnt)
    );

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endfunction

    function automatic bit prod(input bit v, input bit we, input int rd, input int rs,
                                input bit u);
        return v && we && u && (rd == rs) && (rs != 0);
    endfunction

    function automatic stim_t idle();
        stim_t s;
        s.id_valid = 0; s.rs1 = 0; s.rs2 = 0; s.use1 = 0; s.use2 = 0;
        s.exv = 0; s.exwe = 0; s.exld = 0; s.exrd = 0;
        s.memv = 0; s.memwe = 0; s.memrd = 0;
        s.br = 0; s.req = 0; s.ack = 0;
        return s;
    endfunction

    // Apply one cycle of inputs, predict the response and advance the model
    task automatic step(input stim_t s, input string tag);
        exp_t e;
        bit   e1, e2, m1, m2, hazard, blocked;
        @(posedge clk);
        #1;
        pif.id_valid   = s.id_valid;
        pif.id_rs1     = 5'(s.rs1);
        pif.id_rs2     = 5'(s.rs2);
        pif.id_use_rs1 = s.use1;
        pif.id_use_rs2 = s.use2;
        pif.ex_valid   = s.exv;
        pif.ex_reg_we  = s.exwe;
        pif.ex_is_load = s.exld;
        pif.ex_rd      = 5'(s.exrd);
        pif.mem_valid  = s.memv;
        pif.mem_reg_we = s.memwe;
        pif.mem_rd     = 5'(s.memrd);
        pif.br_taken   = s.br;
        pif.dmem_req   = s.req;
        pif.dmem_ack   = s.ack;

        e1 = prod(s.exv, s.exwe, s.exrd, s.rs1, s.use1);
        e2 = prod(s.exv, s.exwe, s.exrd, s.rs2, s.use2);
        m1 = prod(s.memv, s.memwe, s.memrd, s.rs1, s.use1);
        m2 = prod(s.memv, s.memwe, s.memrd, s.rs2, s.use2);
        e.f1 = 0;
        e.f2 = 0;
`ifdef PIPELINE_FORWARDING_EN
        e.f1 = e1 ? 1 : (m1 ? 2 : 0);
        e.f2 = e2 ? 1 : (m2 ? 2 : 0);
        hazard = s.exld && (e1 || e2);
`else
        hazard = e1 || e2 || m1 || m2;
`endif
        blocked = s.req && !s.ack;
        e.sif = 0; e.sid = 0; e.bub = 0; e.fl = 0; e.smem = 0;
        e.st  = m_mode;
        e.cnt = m_cnt;
        e.tag = tag;

        if (m_mode == 2) begin
            if (!s.ack) begin
                e.sif = 1; e.sid = 1; e.smem = 1;
            end
            m_mode = s.ack ? 0 : 2;
        end else if (blocked) begin
            e.sif = 1; e.sid = 1; e.smem = 1;
            m_mode = 2;
        end else if (m_mode == 1) begin
            m_mode = 0;
        end else if (s.br) begin
            e.fl = 1; e.bub = 1;
        end else if (hazard && s.id_valid) begin
            e.sif = 1; e.sid = 1; e.bub = 1;
`ifdef PIPELINE_FORWARDING_EN
            m_mode = 1;
`endif
        end
        if (e.sif && m_cnt < CNT_MAX) m_cnt++;
        q.push_back(e);
    endtask

    // Scoreboard monitor: compare at the falling edge, away from the active edge
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk({e.tag, ".stall_if"},  32'(pif.stall_if),  32'(e.sif));
                chk({e.tag, ".stall_id"},  32'(pif.stall_id),  32'(e.sid));
                chk({e.tag, ".bubble_ex"}, 32'(pif.bubble_ex), 32'(e.bub));
                chk({e.tag, ".flush_id"},  32'(pif.flush_id),  32'(e.fl));
                chk({e.tag, ".stall_mem"}, 32'(pif.stall_mem), 32'(e.smem));
                chk({e.tag, ".fwd_src1"},  32'(pif.fwd_src1),  32'(e.f1));
                chk({e.tag, ".fwd_src2"},  32'(pif.fwd_src2),  32'(e.f2));
                chk({e.tag, ".ctrl_state"}, 32'(ctrl_state),   32'(e.st));
                chk({e.tag, ".stall_cnt"}, 32'(stall_cnt),     32'(e.cnt));
            end
        end
    end

    initial begin
        stim_t s;
        rst = 1'b1;
        s = idle();
        pif.id_valid = 0; pif.id_rs1 = 0; pif.id_rs2 = 0; pif.id_use_rs1 = 0;
        pif.id_use_rs2 = 0; pif.ex_valid = 0; pif.ex_reg_we = 0; pif.ex_is_load = 0;
        pif.ex_rd = 0; pif.mem_valid = 0; pif.mem_reg_we = 0; pif.mem_rd = 0;
        pif.br_taken = 0; pif.dmem_req = 0; pif.dmem_ack = 0;
        #12;
        rst = 1'b0;

        step(idle(), "reset_idle");

        // ALU producer in EX, then MEM, then both
        s = idle(); s.id_valid = 1; s.rs1 = 5; s.use1 = 1;
        s.exv = 1; s.exwe = 1; s.exrd = 5;
        step(s, "fwd_ex");
        s.exv = 0; s.memv = 1; s.memwe = 1; s.memrd = 5;
        step(s, "fwd_mem");
        s.exv = 1;
        step(s, "fwd_both");

        // Load-use on rs2, then the cycle after with the load in MEM
        s = idle(); s.id_valid = 1; s.rs2 = 7; s.use2 = 1;
        s.exv = 1; s.exwe = 1; s.exld = 1; s.exrd = 7;
        step(s, "load_use");
        s.exv = 0; s.exwe = 0; s.exld = 0; s.memv = 1; s.memwe = 1; s.memrd = 7;
        step(s, "load_stall");
        s = idle(); s.id_valid = 1; s.rs2 = 0; s.use2 = 1;
        s.exv = 1; s.exwe = 1; s.exld = 1; s.exrd = 0;
        step(s, "load_x0");

        // Taken branch masks a load-use hazard
        s = idle(); s.id_valid = 1; s.rs1 = 9; s.use1 = 1;
        s.exv = 1; s.exwe = 1; s.exld = 1; s.exrd = 9; s.br = 1;
        step(s, "br_load");

        // Memory wait: ack low for 3 cycles, then ack
        s = idle(); s.req = 1;
        for (int i = 0; i < 3; i++) step(s, "mem_wait");
        s.ack = 1;
        step(s, "mem_ack");
        s = idle(); s.req = 1; s.ack = 1;
        step(s, "mem_same_ack");

        // ALU producer on x3 walking EX -> MEM -> WB
        s = idle(); s.id_valid = 1; s.rs1 = 3; s.use1 = 1;
        s.exv = 1; s.exwe = 1; s.exrd = 3;
        step(s, "alu_ex");
        s.exv = 0; s.memv = 1; s.memwe = 1; s.memrd = 3;
        step(s, "alu_mem");
        s.memv = 0;
        step(s, "alu_wb");

        // Random traffic with a small register range to make hazards frequent
        for (int i = 0; i < 300; i++) begin
            s.id_valid = ($urandom_range(3) != 0);
            s.rs1   = $urandom_range(3);
            s.rs2   = $urandom_range(3);
            s.use1  = $urandom_range(1);
            s.use2  = $urandom_range(1);
            s.exv   = $urandom_range(1);
            s.exwe  = ($urandom_range(3) != 0);
            s.exld  = $urandom_range(1);
            s.exrd  = $urandom_range(3);
            s.memv  = $urandom_range(1);
            s.memwe = ($urandom_range(3) != 0);
            s.memrd = $urandom_range(3);
            s.br    = ($urandom_range(7) == 0);
            s.req   = ($urandom_range(4) == 0);
            s.ack   = $urandom_range(1);
            step(s, "rand");
        end

        // Async reset during the 2nd memory-wait cycle
        s = idle(); s.req = 1;
        step(s, "pre_rst_wait1");
        step(s, "pre_rst_wait2");
        @(negedge clk);
        #2;
        rst = 1'b1;
        pif.dmem_req = 1'b0;
        #1;
        chk("async_rst.ctrl_state", 32'(ctrl_state), 32'd0);
        chk("async_rst.stall_mem", 32'(pif.stall_mem), 32'd0);
        chk("async_rst.stall_if", 32'(pif.stall_if), 32'd0);
        chk("async_rst.stall_id", 32'(pif.stall_id), 32'd0);
        chk("async_rst.stall_cnt", 32'(stall_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        m_mode = 0;
        m_cnt  = 0;
        step(idle(), "post_rst");
        step(idle(), "post_rst2");

        @(negedge clk);
        @(negedge clk);
        chk("queue_drain", 32'(q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
